if_stage: RTL and testbench

Instruction-fetch stage with integrated IF/ID pipeline register. It owns the PC, issues requests to instruction memory over a ready-based handshake, and presents fetched instructions to decode. It consumes the `flush` signal and the branch target from the branch-resolution path: a flush kills the IF/ID contents and any in-flight fetch, then redirects the PC. It also honours the hazard unit's `stall` without losing or duplicating instructions.

---
 rtl/if_stage.sv | 147 ++++++++++++++
 tb/tb_if_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage with the IF/ID pipeline register.
//
// Owns the PC, fetches from instruction memory over a ready handshake
// (data returns in the accepting cycle), and presents instructions to decode.
// A flush kills IF/ID and any in-flight fetch and redirects the PC; a stall
// holds IF/ID, with a one-entry skid buffer catching data that lands while
// decode is stalled.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               taken branch: kill younger instructions, redirect
//   branch_target       redirect PC, used only when flush=1
//   stall               decode cannot accept; hold IF/ID
//   imem_req/imem_addr  fetch request and address (held until accepted)
//   imem_ready          memory accepts the request this cycle
//   imem_rdata          instruction returned with imem_ready
//   if_id_valid/pc/instr  IF/ID pipeline register contents
module if_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [XLEN-1:0] branch_target,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr
);

    // RUN: idle / zero-wait fetch; WAIT: request outstanding;
    // DISCARD: outstanding request was flushed, data will be dropped;
    // HOLD: skid buffer holds an instruction waiting for decode.
    typedef enum logic [1:0] {RUN, WAIT, DISCARD, HOLD} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc, pc_nxt;
    logic [XLEN-1:0] tgt, tgt_nxt;
    logic [31:0]     skid, skid_nxt;
    logic            req;
    logic            deliver;
    logic [31:0]     dlv_instr;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        tgt_nxt   = tgt;
        skid_nxt  = skid;
        req       = 1'b0;
        deliver   = 1'b0;
        dlv_instr = imem_rdata;
        case (state)
            RUN: begin
                req = !stall && !flush;
                if (flush)
                    pc_nxt = branch_target;
                else if (req && imem_ready)
                    deliver = 1'b1;
                else if (req)
                    state_nxt = WAIT;
            end
            WAIT: begin
                req = 1'b1;
                if (imem_ready) begin
                    state_nxt = RUN;
                    if (flush)
                        pc_nxt = branch_target;
                    else if (stall) begin
                        skid_nxt  = imem_rdata;
                        state_nxt = HOLD;
                    end else
                        deliver = 1'b1;
                end else if (flush) begin
                    tgt_nxt   = branch_target;
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                // The request cannot be withdrawn; keep it up and drop its data.
                req = 1'b1;
                if (flush)
                    tgt_nxt = branch_target;
                if (imem_ready) begin
                    pc_nxt    = flush ? branch_target : tgt;
                    state_nxt = RUN;
                end
            end
            HOLD: begin
                if (flush) begin
                    skid_nxt  = '0;
                    pc_nxt    = branch_target;
                    state_nxt = RUN;
                end else if (!stall) begin
                    deliver   = 1'b1;
                    dlv_instr = skid;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
        // pc still points at the instruction being delivered until here.
        if (deliver)
            pc_nxt = pc + XLEN'(4);
    end

    // Request is masked during reset so nothing is issued while the stage is held.
    assign imem_req  = req && rst_n;
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            pc    <= RESET_PC;
            tgt   <= '0;
            skid  <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            tgt   <= tgt_nxt;
            skid  <= skid_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= '0;
        end else if (flush) begin
            if_id_valid <= 1'b0;
        end else if (stall) begin
            if_id_valid <= if_id_valid;
        end else if (deliver) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= pc;
            if_id_instr <= dlv_instr;
        end else begin
            if_id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed test-plan scenarios with literal expectations, then
// randomized ready/stall/flush/reset traffic, all checked every cycle against
// a transaction-level model (outstanding-request flag, kill flag, skid queue).
module tb_if_stage;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            stall = 1'b0;
    logic            imem_ready = 1'b0;
    logic [XLEN-1:0] branch_target = '0;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            if_id_valid;
    logic [XLEN-1:0] if_id_pc;
    logic [31:0]     if_id_instr;

    int tests = 0;
    int fails = 0;

    if_stage #(.XLEN(XLEN), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .branch_target(branch_target),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_rdata = mem(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_tgt, m_ipc, m_ins;
    bit          m_out, m_kill, m_v;
    logic [31:0] m_skid[$];

    task automatic model_reset();
        m_pc = 32'h0; m_tgt = 32'h0; m_ipc = 32'h0; m_ins = 32'h0;
        m_out = 0; m_kill = 0; m_v = 0;
        m_skid.delete();
    endtask

    function automatic bit exp_req();
        if (m_skid.size() != 0) return 0;
        if (m_out) return 1;
        return !stall && !flush;
    endfunction

    task automatic model_step();
        bit          rq, dlv;
        logic [31:0] dins;
        rq = exp_req();
        dlv = 0;
        dins = 32'h0;
        if (m_skid.size() != 0) begin
            if (flush) begin m_skid.delete(); m_pc = branch_target; end
            else if (!stall) begin dlv = 1; dins = m_skid[0]; m_skid.delete(); end
        end else if (m_out && m_kill) begin
            if (flush) m_tgt = branch_target;
            if (imem_ready) begin m_pc = m_tgt; m_out = 0; m_kill = 0; end
        end else if (m_out) begin
            if (imem_ready) begin
                m_out = 0;
                if (flush) m_pc = branch_target;
                else if (stall) m_skid.push_back(mem(m_pc));
                else begin dlv = 1; dins = mem(m_pc); end
            end else if (flush) begin
                m_kill = 1; m_tgt = branch_target;
            end
        end else begin
            if (flush) m_pc = branch_target;
            else if (rq && imem_ready) begin dlv = 1; dins = mem(m_pc); end
            else if (rq) m_out = 1;
        end
        if (flush) m_v = 0;
        else if (stall) m_v = m_v;
        else if (dlv) begin m_v = 1; m_ipc = m_pc; m_ins = dins; end
        else m_v = 0;
        if (dlv) m_pc = m_pc + 32'd4;
    endtask

    // Single compare process: checks outputs mid-cycle, then advances the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
            chkb("rst_req", imem_req, 1'b0);
            chk("rst_addr", imem_addr, 32'h0);
            chkb("rst_valid", if_id_valid, 1'b0);
        end else begin
            chkb("m_req", imem_req, exp_req());
            chk("m_addr", imem_addr, m_pc);
            chkb("m_valid", if_id_valid, m_v);
            if (m_v) begin
                chk("m_pc", if_id_pc, m_ipc);
                chk("m_instr", if_id_instr, m_ins);
            end
            model_step();
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        imem_ready = 1'b1;
        @(negedge clk);
        chk("reset_pc", if_id_pc, 32'h0);
        chk("reset_instr", if_id_instr, 32'h0);
        chkb("reset_valid", if_id_valid, 1'b0);
        chkb("reset_req", imem_req, 1'b0);
        nxt();
        rst_n = 1'b1;
        @(negedge clk);
        chkb("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 32'h0);

        // Zero-wait streaming 0,4,8,C; flush in the cycle pc=0x10.
        for (int i = 0; i < 4; i++) begin
            nxt();
            if (i == 3) begin flush = 1'b1; branch_target = 32'h100; end
            @(negedge clk);
            chkb("seq_valid", if_id_valid, 1'b1);
            chk("seq_pc", if_id_pc, 32'(i * 4));
            chk("seq_instr", if_id_instr, 32'(i * 4) ^ 32'hA5A5_0000);
        end
        chkb("flush_run_req", imem_req, 1'b0);
        nxt(); flush = 1'b0;
        @(negedge clk);
        chkb("flush_bubble", if_id_valid, 1'b0);
        chk("flush_addr", imem_addr, 32'h100);
        nxt();
        @(negedge clk);
        chk("target_pc", if_id_pc, 32'h100);
        chkb("target_valid", if_id_valid, 1'b1);

        // Two wait cycles at 0x8.
        nxt(); flush = 1'b1; branch_target = 32'h8;
        nxt(); flush = 1'b0; imem_ready = 1'b0;
        @(negedge clk);
        chk("wait_addr0", imem_addr, 32'h8);
        nxt();
        @(negedge clk);
        chkb("wait_req1", imem_req, 1'b1);
        chk("wait_addr1", imem_addr, 32'h8);
        chkb("wait_bubble1", if_id_valid, 1'b0);
        nxt(); imem_ready = 1'b1;
        @(negedge clk);
        chk("wait_addr2", imem_addr, 32'h8);
        chkb("wait_bubble2", if_id_valid, 1'b0);

        // Waiting at 0xC, flushed twice before ready.
        nxt(); imem_ready = 1'b0;
        @(negedge clk);
        chk("wait_done_pc", if_id_pc, 32'h8);
        chk("wait_c_addr", imem_addr, 32'hC);
        nxt(); flush = 1'b1; branch_target = 32'h200;
        @(negedge clk);
        chk("disc_addr0", imem_addr, 32'hC);
        nxt(); branch_target = 32'h300;
        @(negedge clk);
        chkb("disc_req1", imem_req, 1'b1);
        chk("disc_addr1", imem_addr, 32'hC);
        nxt(); flush = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        chk("disc_addr2", imem_addr, 32'hC);
        nxt();
        @(negedge clk);
        chk("disc_redirect", imem_addr, 32'h300);
        chkb("disc_dropped", if_id_valid, 1'b0);
        nxt(); flush = 1'b1; branch_target = 32'h14;
        @(negedge clk);
        chk("disc_target_pc", if_id_pc, 32'h300);

        // Stall 3 cycles with ready landing at 0x14.
        nxt(); flush = 1'b0; imem_ready = 1'b0;
        nxt(); stall = 1'b1; imem_ready = 1'b1;
        @(negedge clk);
        chk("skid_addr", imem_addr, 32'h14);
        nxt();
        @(negedge clk);
        chkb("hold_req0", imem_req, 1'b0);
        nxt();
        @(negedge clk);
        chkb("hold_req1", imem_req, 1'b0);
        nxt(); stall = 1'b0;
        @(negedge clk);
        chkb("hold_req2", imem_req, 1'b0);
        chkb("hold_valid", if_id_valid, 1'b0);
        nxt();
        @(negedge clk);
        chk("skid_pc", if_id_pc, 32'h14);
        chk("after_skid_addr", imem_addr, 32'h18);
        nxt();
        @(negedge clk);
        chk("after_skid_pc", if_id_pc, 32'h18);

        // Flush + stall while holding 0x14.
        nxt(); flush = 1'b1; branch_target = 32'h14;
        nxt(); flush = 1'b0; imem_ready = 1'b0;
        nxt(); stall = 1'b1; imem_ready = 1'b1;
        nxt(); flush = 1'b1; branch_target = 32'h40;
        @(negedge clk);
        chkb("hold_flush_req", imem_req, 1'b0);
        nxt(); flush = 1'b0; stall = 1'b0;
        @(negedge clk);
        chkb("hold_flush_valid", if_id_valid, 1'b0);
        chk("hold_flush_addr", imem_addr, 32'h40);
        nxt();
        @(negedge clk);
        chk("hold_flush_pc", if_id_pc, 32'h40);

        // Randomized traffic including occasional mid-transaction resets.
        for (int n = 0; n < 4000; n++) begin
            nxt();
            imem_ready    = ($urandom % 10) < 6;
            stall         = ($urandom % 10) < 2;
            flush         = ($urandom % 12) == 0;
            branch_target = $urandom & 32'h0000_0FFC;
            if (!rst_n) rst_n = 1'b1;
            else if (($urandom % 300) == 0) rst_n = 1'b0;
        end
        nxt();
        rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
